// File: rtl/bic_transmit.sv
// Bit-serial character transmitter: start bit, LSB-first data, stop bit.
// Optional even-parity bit between data and stop when BIC_TX_PARITY_EN is defined.
module bic_transmit #(
   parameter int   DATA_W   = 8,
   parameter logic IDLE_LVL = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              srClock,
   input  logic              transEn,
   input  logic              load,
   input  logic [DATA_W-1:0] charIn,
   output logic              txOut,
   output logic              busy,
   output logic              charSent
);

   localparam int CW = $clog2(DATA_W) + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic [DATA_W-1:0] sh, sh_n;
   logic              tx_n, busy_n, sent_n;
`ifdef BIC_TX_PARITY_EN
   logic              par, par_n;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         txOut    <= IDLE_LVL;
         busy     <= 1'b0;
         charSent <= 1'b0;
         cnt      <= '0;
         sh       <= '0;
`ifdef BIC_TX_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         txOut    <= tx_n;
         busy     <= busy_n;
         charSent <= sent_n;
         cnt      <= cnt_n;
         sh       <= sh_n;
`ifdef BIC_TX_PARITY_EN
         par      <= par_n;
`endif
      end
   end

   always_comb begin
      state_n = state;
      tx_n    = txOut;
      busy_n  = busy;
      sent_n  = 1'b0;
      cnt_n   = cnt;
      sh_n    = sh;
`ifdef BIC_TX_PARITY_EN
      par_n   = par;
`endif
      // Disable wins over everything, including a pending load or strobe
      if (!transEn) begin
         state_n = IDLE;
         tx_n    = IDLE_LVL;
         busy_n  = 1'b0;
         cnt_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               tx_n   = IDLE_LVL;
               busy_n = 1'b0;
               if (load) begin
                  state_n = START;
                  tx_n    = 1'b0;
                  busy_n  = 1'b1;
                  cnt_n   = '0;
                  sh_n    = charIn;
`ifdef BIC_TX_PARITY_EN
                  par_n   = 1'b0;
`endif
               end
            end
            START: begin
               if (srClock) begin
                  state_n = DATA;
                  tx_n    = sh[0];
               end
            end
            DATA: begin
               if (srClock) begin
                  sh_n = sh >> 1;
`ifdef BIC_TX_PARITY_EN
                  par_n = par ^ sh[0];
`endif
                  if (cnt == CW'(DATA_W - 1)) begin
                     cnt_n = '0;
`ifdef BIC_TX_PARITY_EN
                     state_n = PARITY;
                     tx_n    = par ^ sh[0];
`else
                     state_n = STOP;
                     tx_n    = IDLE_LVL;
`endif
                  end else begin
                     cnt_n = cnt + 1'b1;
                     tx_n  = sh_n[0];
                  end
               end
            end
`ifdef BIC_TX_PARITY_EN
            PARITY: begin
               if (srClock) begin
                  state_n = STOP;
                  tx_n    = IDLE_LVL;
               end
            end
`endif
            STOP: begin
               if (srClock) begin
                  state_n = IDLE;
                  tx_n    = IDLE_LVL;
                  busy_n  = 1'b0;
                  sent_n  = 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               tx_n    = IDLE_LVL;
               busy_n  = 1'b0;
               cnt_n   = '0;
            end
         endcase
      end
   end

endmodule
